// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: bundle of every non-clock signal around systolic_feeder.
//   Host side  : in_valid/in_ready + a/b (operands), c/out_valid/out_ready (result).
//   Array side : row/col skewed streams, do_process enable, array_c (array o_c).
//   Status     : busy (job in RUN or CAPT), state (FSM state, debug visibility).
// Modports:
//   slave  - the feeder's view (drives ready, streams, result, status).
//   master - the environment's view (host plus systolic array).
interface systolic_feeder_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  localparam int S = 2*N-1;

  logic                               in_valid;
  logic                               in_ready;
  logic [N-1:0][N-1:0][DATA_W-1:0]    a;          // a[row][k]
  logic [N-1:0][N-1:0][DATA_W-1:0]    b;          // b[k][col]
  logic [N-1:0][S-1:0][DATA_W-1:0]    row;        // row[i][slot], slot 0 consumed
  logic [N-1:0][S-1:0][DATA_W-1:0]    col;        // col[j][slot], slot 0 consumed
  logic                               do_process;
  logic [N-1:0][N-1:0][ACC_W-1:0]     array_c;
  logic [N-1:0][N-1:0][ACC_W-1:0]     c;
  logic                               out_valid;
  logic                               out_ready;
  logic                               busy;
  logic [1:0]                         state;

  modport slave (
    input  in_valid, a, b, array_c, out_ready,
    output in_ready, row, col, do_process, c, out_valid, busy, state
  );

  modport master (
    output in_valid, a, b, array_c, out_ready,
    input  in_ready, row, col, do_process, c, out_valid, busy, state
  );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: sequencing front/back end for an NxN output-stationary
// systolic array. Accepts one A/B job, loads skewed row/col streams, holds
// do_process for RUN_CYCLES cycles while shifting the streams toward slot 0,
// captures the array result one cycle later and offers it downstream.
//
// Ports:
//   clk   - clock, rising edge
//   srst  - synchronous active-high reset (returns to IDLE from any state)
//   bus   - systolic_feeder_if.slave: operand handshake, array streams and
//           enable, captured result handshake, busy and debug state.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Valid, once raised by the feeder, stays high with stable data
// until that transfer; ready may depend combinationally on the partner's ready
// but never on the partner's valid.
//
// Configuration macro SYSTOLIC_FEEDER_OVERLAP_EN: when defined, a new job may
// be accepted in the same cycle the previous result is handed off (DONE goes
// straight to RUN). When undefined, jobs are only accepted in IDLE.
module systolic_feeder #(
  parameter int N          = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int RUN_CYCLES = 3*N-2
) (
  input logic          clk,
  input logic          srst,
  systolic_feeder_if.slave bus
);
  localparam int S  = 2*N-1;
  localparam int CW = $clog2(RUN_CYCLES+1);

  localparam logic [1:0] ST_IDLE = 2'd0,
                         ST_RUN  = 2'd1,
                         ST_CAPT = 2'd2,
                         ST_DONE = 2'd3;

  logic [1:0]                       state;
  logic [CW-1:0]                    cnt;
  logic [N-1:0][S-1:0][DATA_W-1:0]  row_q;
  logic [N-1:0][S-1:0][DATA_W-1:0]  col_q;
  logic [N-1:0][S-1:0][DATA_W-1:0]  row_load;
  logic [N-1:0][S-1:0][DATA_W-1:0]  col_load;
  logic [N-1:0][N-1:0][ACC_W-1:0]   c_q;
  logic                             in_ready_w;
  logic                             accept;

  // Skewed load images: stream i is delayed by i slots so that element k of
  // row i and of column j meet at PE(i,j) on the same cycle.
  for (genvar i = 0; i < N; i++) begin : g_skew_i
    for (genvar s = 0; s < S; s++) begin : g_skew_s
      if (s >= i && s < i + N) begin : g_data
        assign row_load[i][s] = bus.a[i][s-i];
        assign col_load[i][s] = bus.b[s-i][i];
      end else begin : g_zero
        assign row_load[i][s] = '0;
        assign col_load[i][s] = '0;
      end
    end
  end

`ifdef SYSTOLIC_FEEDER_OVERLAP_EN
  assign in_ready_w = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
`else
  assign in_ready_w = (state == ST_IDLE);
`endif

  assign accept = bus.in_valid && in_ready_w;

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      row_q <= '0;
      col_q <= '0;
      c_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            row_q <= row_load;
            col_q <= col_load;
            cnt   <= CW'(RUN_CYCLES - 1);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Every stream moves one slot toward slot 0; zeros enter the top.
          for (int i = 0; i < N; i++) begin
            row_q[i] <= row_q[i] >> DATA_W;
            col_q[i] <= col_q[i] >> DATA_W;
          end
          if (cnt == '0) begin
            state <= ST_CAPT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CAPT: begin
          // do_process is low here, which also lets the array clear its
          // accumulators before the next job.
          c_q   <= bus.array_c;
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            // accept can only be true here when overlap is enabled.
            if (accept) begin
              row_q <= row_load;
              col_q <= col_load;
              cnt   <= CW'(RUN_CYCLES - 1);
              state <= ST_RUN;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.do_process = (state == ST_RUN);
  assign bus.c          = c_q;
  assign bus.out_valid  = (state == ST_DONE);
  assign bus.busy       = (state == ST_RUN) || (state == ST_CAPT);
  assign bus.state      = state;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: drives systolic_feeder with directed and random jobs,
// emulates the external systolic array, and checks captured results through a
// scoreboard queue filled at accept time and drained by an output monitor.
module tb_systolic_feeder;
  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int W      = N*N*ACC_W;

  typedef logic [N-1:0][N-1:0][DATA_W-1:0] mat_t;
  typedef logic [N-1:0][N-1:0][ACC_W-1:0]  res_t;

  logic clk;
  logic srst;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q[$];

  systolic_feeder_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  systolic_feeder #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- external array emulation ----------------
  // Output-stationary grid: operands enter at column 0 / row 0 from stream
  // slot 0, hop one PE per cycle, accumulators clear whenever disabled.
  logic [DATA_W-1:0] pa[N][N];
  logic [DATA_W-1:0] pb[N][N];
  logic [DATA_W-1:0] ain[N][N];
  logic [DATA_W-1:0] bin[N][N];
  logic [ACC_W-1:0]  acc[N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ain[i][j] = bus.row[i][0];
        else        ain[i][j] = pa[i][j-1];
        if (i == 0) bin[i][j] = bus.col[j][0];
        else        bin[i][j] = pb[i-1][j];
        bus.array_c[i][j] = acc[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!bus.do_process) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= ain[i][j];
          pb[i][j]  <= bin[i][j];
          acc[i][j] <= acc[i][j] + ACC_W'(ain[i][j]) * ACC_W'(bin[i][j]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic res_t matmul(input mat_t a, input mat_t b);
    res_t r;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(a[i][k]) * longint'(b[k][j]);
        r[i][j] = ACC_W'(s);
      end
    end
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[i][j] = DATA_W'($urandom_range(0, 255));
    return m;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!srst && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL c_unexpected got=%h required=none", bus.c);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.c !== e) begin
          bad++;
          $display("FAIL c_result got=%h required=%h", bus.c, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Waits for in_ready, presents one job for exactly the accept cycle, then
  // scrambles the operand inputs (they must be ignored afterwards).
  task automatic issue(input mat_t a, input mat_t b);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=0 required=1");
      return;
    end
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    exp_q.push_back(matmul(a, b));
    step();
    bus.in_valid = 1'b0;
    bus.a        = rand_mat();
    bus.b        = rand_mat();
  endtask

  // cyc holds the current cycle number relative to the accept edge.
  task automatic wait_valid(inout int cyc);
    while (!bus.out_valid && cyc < 60) begin
      step();
      cyc++;
    end
    if (!bus.out_valid) begin
      total++;
      bad++;
      $display("FAIL valid_timeout got=0 required=1");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mat_t ma, mb, held_a;
    res_t held;
    int   cyc, dp, b2b_exp;

    srst          = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_do_process", bus.do_process, 0);
    chk("rst_busy", bus.busy, 0);
    srst = 1'b0;
    step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_row_zero", bus.row == '0, 1);
    chk("rst_col_zero", bus.col == '0, 1);
    chk("rst_c_zero", bus.c == '0, 1);

    // Identity x counting matrix, with latency and enable-length checks.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 8'd1 : 8'd0;
        mb[i][j] = DATA_W'(4*i + j + 1);
      end
    issue(ma, mb);
    chk("run_busy", bus.busy, 1);
    chk("run_in_ready", bus.in_ready, 0);
    cyc = 1;
    dp  = 0;
    while (!bus.out_valid && cyc < 60) begin
      if (bus.do_process) dp++;
      step();
      cyc++;
    end
    chk("first_valid_cycle", 64'(cyc), 12);
    chk("do_process_cycles", 64'(dp), 10);
    chk("ident_c12", bus.c[1][2], 32'd7);
    step();
    chk("valid_drop", bus.out_valid, 0);

    // All-ones operands: largest possible result.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) ma[i][j] = 8'hFF;
    issue(ma, ma);
    cyc = 1;
    wait_valid(cyc);
    chk("ff_c00", bus.c[0][0], 32'h0003_F804);
    chk("ff_c33", bus.c[3][3], 32'h0003_F804);
    step();

    // Skew pattern A[i][k] = 16i+k.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) ma[i][k] = DATA_W'(16*i + k);
    mb = rand_mat();
    issue(ma, mb);
    chk("skew_c1_row10", bus.row[1][0], 8'h00);
    chk("skew_c1_row11", bus.row[1][1], 8'h10);
    chk("skew_c1_col00", bus.col[0][0], mb[0][0]);
    chk("skew_c1_col22", bus.col[2][2], mb[0][2]);
    step();
    chk("skew_c2_row10", bus.row[1][0], 8'h10);
    step();
    chk("skew_c3_row30", bus.row[3][0], 8'h00);
    step();
    chk("skew_c4_row30", bus.row[3][0], 8'h30);
    cyc = 4;
    wait_valid(cyc);
    step();

    // Downstream stall: result held, new requests ignored.
    bus.out_ready = 1'b0;
    issue(rand_mat(), rand_mat());
    cyc = 1;
    wait_valid(cyc);
    held = bus.c;
    held_a = rand_mat();
    for (int k = 0; k < 5; k++) begin
      chk("stall_c_stable", bus.c == held, 1);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_in_ready", bus.in_ready, 0);
      bus.in_valid = 1'b1;
      bus.a        = held_a;
      step();
    end
    chk("stall_not_busy", bus.busy, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("stall_release_drop", bus.out_valid, 0);

    // Reset in the middle of a job.
    issue(rand_mat(), rand_mat());
    repeat (4) step();
    chk("midrst_running", bus.do_process, 1);
    srst = 1'b1;
    exp_q.delete();
    step();
    srst = 1'b0;
    chk("midrst_do_process", bus.do_process, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_row_zero", bus.row == '0, 1);
    issue(rand_mat(), rand_mat());
    cyc = 1;
    wait_valid(cyc);
    step();

    // Random jobs with random downstream back-pressure.
    for (int t = 0; t < 6; t++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      issue(rand_mat(), rand_mat());
      cyc = 1;
      wait_valid(cyc);
      repeat ($urandom_range(0, 3)) step();
      bus.out_ready = 1'b1;
      step();
    end

    // Back-to-back jobs with the second request held from cycle 1.
    bus.out_ready = 1'b1;
    issue(rand_mat(), rand_mat());
    ma = rand_mat();
    mb = rand_mat();
    bus.a        = ma;
    bus.b        = mb;
    bus.in_valid = 1'b1;
    cyc = 1;
    while (!bus.in_ready && cyc < 60) begin
      step();
      cyc++;
    end
`ifdef SYSTOLIC_FEEDER_OVERLAP_EN
    b2b_exp = 12;
`else
    b2b_exp = 13;
`endif
    chk("b2b_accept_cycle", 64'(cyc), 64'(b2b_exp));
    exp_q.push_back(matmul(ma, mb));
    step();
    bus.in_valid = 1'b0;
    cyc = 1;
    wait_valid(cyc);
    chk("b2b_second_latency", 64'(cyc), 12);
    step();

    repeat (3) step();
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
